// File: rtl/tablememory_pkg.sv
// Shared definitions for the 7x5 SR-latch table memory sequencer.
//   - Board geometry and the (column, row) -> flat bit index mapping.
//   - Command op and response status encodings.
//   - Sequencer FSM state encoding.
package tablememory_pkg;

  localparam int NCOLS  = 7;
  localparam int NROWS  = 5;
  localparam int NCELLS = NCOLS * NROWS;
  localparam int IDX_W  = 6;

  localparam logic OP_DROP  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_FULL   = 2'b01;
  localparam logic [1:0] ST_BADCOL = 2'b10;
  localparam logic [1:0] ST_VERIFY = 2'b11;

  typedef enum logic [2:0] {
    S_INIT_CLR = 3'd0,
    S_IDLE     = 3'd1,
    S_SCAN     = 3'd2,
    S_SET      = 3'd3,
    S_VERIFY   = 3'd4,
    S_CLR      = 3'd5,
    S_RESP     = 3'd6
  } state_e;

  // Row-major with row 0 at the bottom: bit index = r*NCOLS + c.
  function automatic logic [IDX_W-1:0] CELL_IDX(input logic [2:0] c, input logic [2:0] r);
    return IDX_W'(r) * IDX_W'(NCOLS) + IDX_W'(c);
  endfunction

endpackage

// File: rtl/tablememory_pulse_timer.sv
// Down-counter that times one latch write pulse of PULSE_CYC cycles.
//   clk, reset_n : clock, async active-low reset
//   start        : load the counter with PULSE_CYC
//   busy         : counter non-zero (a pulse is in progress)
//   done         : last cycle of the pulse (counter == 1)
module tablememory_pulse_timer #(
  parameter int PULSE_CYC = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(PULSE_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = CW'(PULSE_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/tablememory_drop_ctrl.sv
// Sequencer for the 7x5 SR-latch table memory. Accepts DROP(column) and
// CLEAR commands, scans a column bottom-up for the first empty cell, pulses
// that cell's S line and reads Q back to verify. Sole driver of all S/R lines.
//   clk, reset_n           : clock, async active-low reset
//   cmd_valid/ready/op/col : command handshake (ready only in IDLE)
//   rsp_valid/status/row   : one-cycle completion pulse with result
//   cell_s, cell_r         : registered S/R lines, bit r*NCOLS+c
//   cell_q                 : latch outputs, same indexing
//   board_full             : registered AND of all cell_q bits
module tablememory_drop_ctrl
  import tablememory_pkg::*;
#(
  parameter int PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_col,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [2:0]        rsp_row,
  output logic [NCELLS-1:0] cell_s,
  output logic [NCELLS-1:0] cell_r,
  input  logic [NCELLS-1:0] cell_q,
  output logic              board_full
);

  state_e             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [1:0]         status_q, status_d;
  logic [2:0]         rsp_row_q, rsp_row_d;
  logic [NCELLS-1:0]  cell_s_q, cell_s_d;
  logic [NCELLS-1:0]  cell_r_q, cell_r_d;
  logic               board_full_q, board_full_d;
  logic               tmr_start, tmr_busy, tmr_done;
  logic [IDX_W-1:0]   cur_idx;

  tablememory_pulse_timer #(.PULSE_CYC(PULSE_CYC)) u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tmr_start),
    .busy    (tmr_busy),
    .done    (tmr_done)
  );

  assign cur_idx = CELL_IDX(col_q, row_q);

  // S/R next values are decoded from the upcoming state so the lines come
  // straight off flops. A pulse line is held until the timer's done cycle,
  // which gives exactly PULSE_CYC high cycles after the starting edge.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    status_d     = status_q;
    rsp_row_d    = rsp_row_q;
    cell_s_d     = '0;
    cell_r_d     = '0;
    tmr_start    = 1'b0;
    board_full_d = &cell_q;

    case (state_q)
      S_INIT_CLR: begin
        // First cycle out of reset the timer is idle: kick off the clear pulse.
        if (!tmr_busy) begin
          tmr_start = 1'b1;
          cell_r_d  = '1;
        end else if (tmr_done) begin
          state_d = S_IDLE;
        end else begin
          cell_r_d = '1;
        end
      end

      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_CLEAR) begin
            state_d   = S_CLR;
            tmr_start = 1'b1;
            cell_r_d  = '1;
          end else if (cmd_col >= 3'(NCOLS)) begin
            state_d   = S_RESP;
            status_d  = ST_BADCOL;
            rsp_row_d = '0;
          end else begin
            state_d = S_SCAN;
            col_d   = cmd_col;
            row_d   = '0;
          end
        end
      end

      S_SCAN: begin
        if (!cell_q[cur_idx]) begin
          state_d            = S_SET;
          tmr_start          = 1'b1;
          cell_s_d[cur_idx]  = 1'b1;
        end else if (row_q == 3'(NROWS - 1)) begin
          state_d   = S_RESP;
          status_d  = ST_FULL;
          rsp_row_d = '0;
        end else begin
          row_d = row_q + 3'd1;
        end
      end

      S_SET: begin
        if (tmr_done)
          state_d = S_VERIFY;
        else
          cell_s_d[cur_idx] = 1'b1;
      end

      S_VERIFY: begin
        state_d = S_RESP;
        if (cell_q[cur_idx]) begin
          status_d  = ST_OK;
          rsp_row_d = row_q;
        end else begin
          status_d  = ST_VERIFY;
          rsp_row_d = '0;
        end
      end

      S_CLR: begin
        if (tmr_done) begin
          state_d   = S_RESP;
          status_d  = ST_OK;
          rsp_row_d = '0;
        end else begin
          cell_r_d = '1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT_CLR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT_CLR;
      row_q        <= '0;
      col_q        <= '0;
      status_q     <= '0;
      rsp_row_q    <= '0;
      cell_s_q     <= '0;
      cell_r_q     <= '0;
      board_full_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      status_q     <= status_d;
      rsp_row_q    <= rsp_row_d;
      cell_s_q     <= cell_s_d;
      cell_r_q     <= cell_r_d;
      board_full_q <= board_full_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_status = status_q;
  assign rsp_row    = rsp_row_q;
  assign cell_s     = cell_s_q;
  assign cell_r     = cell_r_q;
  assign board_full = board_full_q;

endmodule
